debug_display_scanner: RTL
==========================

DEBUG_DISPLAY_SCANNER -- requirements
Module: debug_display_scanner

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CH, 8, number of debug channels, 2..16.
- DATA_W, 16, channel width in bits, a multiple of 4 (whole hex digits).
- SCAN_DIV, 50000000, auto-scan dwell in Clk cycles, at least 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk, in, 1, sole clock, rising edge.
- Reset, in, 1, asynchronous, active-high.
- ch_data, in, NUM_CH*DATA_W, packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
- sel, in, 4, manual channel select.
- auto_en, in, 1, 1 = auto-scan, 0 = manual.
- step, in, 1, single-cycle advance pulse.
- freeze, in, 1, level hold request.
- disp_data, out, DATA_W, displayed word, registered.
- disp_ch, out, 4, displayed channel index, registered.
- scan_tick, out, 1, one-cycle pulse on each auto advance.
- frozen, out, 1, high while the snapshot is shown.
REQ-003 Clock and reset SHALL be the single clock Clk and reset Reset; Reset SHALL be asynchronous and active-high.

Function
REQ-004 The channel FSM SHALL have two states:
- MANUAL when auto_en=0.
- AUTO when auto_en=1.
- The state is registered; transitions are evaluated every cycle.
REQ-005 In MANUAL, disp_ch SHALL load sel one cycle later, clamped to NUM_CH-1 when sel >= NUM_CH; step SHALL be ignored.
REQ-006 In AUTO, a prescaler SHALL count 0..SCAN_DIV-1.
- At terminal count it wraps to 0, disp_ch advances by one, and scan_tick is high for exactly that cycle.
REQ-007 disp_ch SHALL wrap from NUM_CH-1 to 0.
REQ-008 In AUTO, step=1 SHALL advance disp_ch immediately, clear the prescaler and not assert scan_tick.
- step coinciding with terminal count SHALL give exactly one advance.
REQ-009 The MANUAL->AUTO transition SHALL clear the prescaler and keep the current disp_ch.
- The AUTO->MANUAL transition SHALL clear the prescaler; disp_ch takes sel on the next cycle.
REQ-010 disp_data SHALL update on the same edge as disp_ch and carry the word of the channel being loaded into disp_ch.
- Live data is sampled on that edge, so both outputs present a consistent pair with 1-cycle latency.
REQ-011 scan_tick SHALL be 0 in MANUAL.
REQ-012 All outputs SHALL come directly from registers.

Reset
REQ-013 Asserting Reset SHALL immediately force the following to 0, independent of Clk:
- outputs disp_ch, disp_data, scan_tick, frozen;
- state (MANUAL), prescaler and snapshot bank.
REQ-014 Reset asserted mid-scan or mid-freeze SHALL abandon it with no residual state; the first post-reset edge behaves as from power-up.

Configuration
REQ-015 Macro DBG_SNAPSHOT_FREEZE_EN, when defined, SHALL enable snapshot freeze:
- A 0->1 edge on freeze captures all NUM_CH channels into a snapshot bank on that clock edge.
- While freeze=1, disp_data sources from the snapshot and frozen=1; channel selection and scanning continue.
- After freeze falls, live data and frozen=0 take effect from the next edge.
REQ-016 When DBG_SNAPSHOT_FREEZE_EN is not defined:
- The freeze input SHALL be ignored and frozen SHALL be tied to 0.
- No snapshot storage SHALL be synthesised.

Verification
REQ-017 Benches SHALL use NUM_CH=8, DATA_W=16, SCAN_DIV=4, with ch_data channel k = 16'hA000+k. Required scenarios:
- Manual: sel=5 -> next cycle disp_ch=5, disp_data=16'hA005; sel=12 -> disp_ch=7, disp_data=16'hA007.
- Auto wrap: auto_en=1 from disp_ch=6 -> scan_tick every 4th cycle; disp_ch sequence 7, 0, 1 with disp_data tracking.
- Step collision: step coincides with terminal count at disp_ch=2 -> disp_ch=3 exactly once, scan_tick=0, next tick 4 cycles later.
- Freeze (macro defined): freeze rises, then ch_data changes to 16'hFFFF -> disp_data keeps 16'hA00k while scanning, frozen=1; freeze falls -> 16'hFFFF next cycle.
- Freeze (macro undefined): freeze=1 -> frozen=0 and disp_data follows live data.
- Reset: Reset pulsed mid-auto-scan between clock edges -> all outputs 0 at once; manual sel=0 behaviour follows release.

Source files
------------

// File: rtl/debug_display_scanner.sv
// Debug display scanner: shows one of NUM_CH packed channels, selected manually or by a timed auto-scan.
// Optional snapshot freeze is compiled in when DBG_SNAPSHOT_FREEZE_EN is defined.
module debug_display_scanner #(
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 16,
    parameter int SCAN_DIV = 50000000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [3:0]               sel,
    input  logic                     auto_en,
    input  logic                     step,
    input  logic                     freeze,
    output logic [DATA_W-1:0]        disp_data,
    output logic [3:0]               disp_ch,
    output logic                     scan_tick,
    output logic                     frozen
);
    localparam int              PW      = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   TERM    = PW'(SCAN_DIV - 1);
    localparam logic [3:0]      LAST_CH = 4'(NUM_CH - 1);

    typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

    state_t                   r_state, w_state_next;
    logic [PW-1:0]            r_presc, w_presc_next;
    logic [3:0]               r_disp_ch, w_ch_next, w_sel_clamp, w_ch_inc;
    logic [DATA_W-1:0]        r_disp_data, w_word;
    logic                     r_scan_tick, w_tick_next;
    logic [NUM_CH*DATA_W-1:0] w_src;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_MANUAL;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_ch_next    = r_disp_ch;
        w_tick_next  = 1'b0;
        w_sel_clamp  = ({1'b0, sel} >= 5'(NUM_CH)) ? LAST_CH : sel;
        w_ch_inc     = (r_disp_ch == LAST_CH) ? 4'd0 : r_disp_ch + 4'd1;
        case (r_state)
            ST_MANUAL: begin
                if (auto_en) begin
                    // Entering auto keeps the channel already on display.
                    w_state_next = ST_AUTO;
                    w_presc_next = '0;
                end else begin
                    w_ch_next = w_sel_clamp;
                end
            end
            ST_AUTO: begin
                if (!auto_en) begin
                    w_state_next = ST_MANUAL;
                    w_presc_next = '0;
                    w_ch_next    = w_sel_clamp;
                end else if (step) begin
                    // A step wins over a coinciding terminal count: one advance, no tick.
                    w_ch_next    = w_ch_inc;
                    w_presc_next = '0;
                end else if (r_presc == TERM) begin
                    w_ch_next    = w_ch_inc;
                    w_presc_next = '0;
                    w_tick_next  = 1'b1;
                end else begin
                    w_presc_next = r_presc + 1'b1;
                end
            end
            default: w_state_next = ST_MANUAL;
        endcase
    end

    assign w_word = w_src[int'(w_ch_next)*DATA_W +: DATA_W];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_presc     <= '0;
            r_disp_ch   <= '0;
            r_disp_data <= '0;
            r_scan_tick <= 1'b0;
        end else begin
            r_presc     <= w_presc_next;
            r_disp_ch   <= w_ch_next;
            r_disp_data <= w_word;
            r_scan_tick <= w_tick_next;
        end
    end

`ifdef DBG_SNAPSHOT_FREEZE_EN
    logic                     r_freeze_d;
    logic                     r_frozen;
    logic [NUM_CH*DATA_W-1:0] r_snap;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_freeze_d <= 1'b0;
            r_frozen   <= 1'b0;
            r_snap     <= '0;
        end else begin
            r_freeze_d <= freeze;
            r_frozen   <= freeze;
            if (freeze && !r_freeze_d) r_snap <= ch_data;
        end
    end

    // On the capture edge the bank is still loading, so live data equals the snapshot.
    assign w_src  = (freeze && r_freeze_d) ? r_snap : ch_data;
    assign frozen = r_frozen;
`else
    logic w_unused_freeze;
    assign w_unused_freeze = freeze;
    assign w_src           = ch_data;
    assign frozen          = 1'b0;
`endif

    assign disp_ch   = r_disp_ch;
    assign disp_data = r_disp_data;
    assign scan_tick = r_scan_tick;
endmodule
